synth_voice_sequencer: RTL and testbench
========================================

# synth_voice_sequencer

Drives the four-voice wavetable generator as its initiator. Owns the per-voice NCO phase accumulators and the sample-rate tick. On each tick it advances the phases, issues one generator request, collects the four returned samples and mixes them. It presents one mixed sample per tick to the downstream audio sink over a valid/ready handshake.

## Interface
- `SAMPLE_DIV`, 2500: clock cycles per audio sample; 125 MHz gives 50 kHz.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `fcw_1`..`fcw_4` in 24 each: per-voice frequency control words, unsigned, sampled on tick acceptance.
- `voice_en` in 4: per-voice enable; bit n-1 controls voice n.
- `phase_1`..`phase_4` out 24 each: accumulated phases, connected to the generator phase inputs.
- `gen_valid` out 1: one-cycle request pulse, connected to the generator `in_valid`.
- `wave_1`..`wave_4` in 21 each: generator samples, signed two's complement.
- `wave_valid` in 1: generator `out_valid`.
- `sample_data` out 21: mixed sample, signed.
- `sample_valid` out 1: mixed sample available.
- `sample_ready` in 1: sink accepts the sample.
- `busy` out 1: high whenever the state is not IDLE.
- `overrun_cnt` out 8: dropped-tick count; saturates at 255.
- `timeout_err` out 1: sticky; set when the generator fails to respond.

## Operation
- Tick divider:
  - Counter runs 0..SAMPLE_DIV-1 and wraps.
  - On wrap, `tick_pending` is set.
  - If `tick_pending` is already set at a wrap, the new tick is dropped and `overrun_cnt` increments (saturating).
- State machine: IDLE, ISSUE, WAIT, MIX, OUTPUT.
- IDLE: when `tick_pending` is set, clear it and go to ISSUE. On the same edge, for each voice n:
  - if enabled: `phase_n <= phase_n + fcw_n`, mod 2^24;
  - if disabled: `phase_n <= 0`.
- ISSUE: `gen_valid`=1 for exactly this cycle; next state is WAIT. The timeout counter clears.
- WAIT:
  - When `wave_valid` is seen, capture `wave_1`..`wave_4` and go to MIX.
  - The timeout counter increments each cycle. When it reaches WAIT_TIMEOUT (16) without `wave_valid`, set `timeout_err`, go to IDLE and emit no sample.
- MIX:
  - Sign-extend each enabled voice to 23 bits and sum them. Disabled voices contribute 0.
  - Register the result into `sample_data`, with width reduction per Configuration.
  - Next state is OUTPUT.
- OUTPUT: `sample_valid`=1 until the cycle in which `sample_ready`=1, then go to IDLE.
- Phase stability: `phase_1`..`phase_4` are constant from the ISSUE cycle until the state returns to IDLE. The generator reads them combinationally over several cycles.
- `wave_valid` outside WAIT is ignored.
- Ticks arriving while not in IDLE stay pending (one deep); a further tick is counted as an overrun.
- With `voice_en`=0, a sample of 0 is still produced each tick.

## Timing
- Reset values: phases 0, `gen_valid` 0, `sample_valid` 0, `sample_data` 0, `busy` 0, `overrun_cnt` 0, `timeout_err` 0, divider 0, `tick_pending` 0, state IDLE.
- Reset applied mid-operation aborts the transaction on the next edge; state returns to IDLE.
- Cycle sequence for a pending tick seen in IDLE at cycle t:
  - ISSUE (`gen_valid`) at t+1.
  - Generator `out_valid` at t+8, 7-cycle generator latency.
  - MIX at t+9.
  - `sample_valid` at t+10.
- A transaction takes a minimum of 10 cycles; SAMPLE_DIV ≥ 16 is required.
- `sample_data` is stable while `sample_valid`=1.

## Configuration
- `SYNTH_MIX_SAT_EN` defined: `sample_data` = 23-bit sum saturated to the 21-bit signed range [-1048576, 1048575].
- Not defined: `sample_data` = 23-bit sum arithmetically shifted right by 2 (average of four), with no saturation logic.

## Structure
- Package `synth_pkg`:
  - PHASE_W=24, WAVE_W=21, NUM_VOICES=4, WAIT_TIMEOUT=16, GEN_LATENCY=7;
  - state enum type.
- Sub-module `sample_tick_gen`: divider counter with a one-cycle tick output.
- Accumulators, FSM and mixer live in the top module.

## Test plan
- SAMPLE_DIV=16, `fcw_1`=0x004000, `voice_en`=0001:
  - successive ticks give `phase_1` = 0x004000, then 0x008000, then 0x00C000;
  - `gen_valid` is a single pulse per tick;
  - phases are stable until IDLE.
- Wrap: `fcw_1`=0xC00000 -> `phase_1` = 0xC00000, then 0x800000, then 0x400000. Disabling voice 1 forces `phase_1` to 0 on the next tick.
- Mix: bench model returns all waves equal to 500000 with `voice_en`=1111:
  - `SYNTH_MIX_SAT_EN` defined: `sample_data`=1048575; not defined: 500000.
  - With all waves at -600000: -1048576 and -600000 respectively.
- Backpressure: `sample_ready` held low for 3 sample periods:
  - `sample_valid` stays high and `sample_data` is unchanged;
  - `overrun_cnt`=2 (one tick held pending, two dropped).
- Timeout: `wave_valid` never asserted -> 16 cycles after ISSUE, `timeout_err`=1 and state is IDLE with no `sample_valid`; the next tick proceeds normally.
- Reset mid-WAIT: `rst_n` low one cycle -> all outputs at reset values next edge. A later `wave_valid` produces no sample.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared widths, timing constants and FSM state type for the voice sequencer.
package synth_pkg;

  localparam int unsigned PHASE_W      = 24;
  localparam int unsigned WAVE_W       = 21;
  localparam int unsigned NUM_VOICES   = 4;
  localparam int unsigned WAIT_TIMEOUT = 16;
  localparam int unsigned GEN_LATENCY  = 7;
  localparam int unsigned MIX_W        = WAVE_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_MIX,
    ST_OUTPUT
  } seq_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..SAMPLE_DIV-1 and pulses o_tick for the wrap cycle.
module sample_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 2500
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned CW = $clog2(SAMPLE_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(SAMPLE_DIV - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/synth_voice_sequencer.sv
// Four-voice NCO sequencer: per-tick phase advance, generator request, mix, sink handshake.
// Build option: define SYNTH_MIX_SAT_EN to saturate the mix instead of averaging it.
module synth_voice_sequencer
  import synth_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 2500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] fcw_1,
  input  logic [PHASE_W-1:0] fcw_2,
  input  logic [PHASE_W-1:0] fcw_3,
  input  logic [PHASE_W-1:0] fcw_4,
  input  logic [3:0]         voice_en,
  output logic [PHASE_W-1:0] phase_1,
  output logic [PHASE_W-1:0] phase_2,
  output logic [PHASE_W-1:0] phase_3,
  output logic [PHASE_W-1:0] phase_4,
  output logic               gen_valid,
  input  logic [WAVE_W-1:0]  wave_1,
  input  logic [WAVE_W-1:0]  wave_2,
  input  logic [WAVE_W-1:0]  wave_3,
  input  logic [WAVE_W-1:0]  wave_4,
  input  logic               wave_valid,
  output logic [WAVE_W-1:0]  sample_data,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               busy,
  output logic [7:0]         overrun_cnt,
  output logic               timeout_err
);

  localparam int unsigned TO_W = $clog2(WAIT_TIMEOUT + 1);

  seq_state_t                r_state;
  seq_state_t                w_next;
  logic                      w_tick;
  logic                      w_take;
  logic                      w_timeout;
  logic                      r_tick_pending;
  logic [TO_W-1:0]           r_to_cnt;
  logic [TO_W-1:0]           w_to_next;
  logic [NUM_VOICES-1:0]     r_en;
  logic [PHASE_W-1:0]        w_fcw   [NUM_VOICES];
  logic [PHASE_W-1:0]        r_phase [NUM_VOICES];
  logic signed [WAVE_W-1:0]  w_wave  [NUM_VOICES];
  logic signed [WAVE_W-1:0]  r_wave  [NUM_VOICES];
  logic signed [MIX_W-1:0]   w_sum;
  logic [WAVE_W-1:0]         w_mix;

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_tick  (w_tick)
  );

  assign w_fcw[0] = fcw_1;
  assign w_fcw[1] = fcw_2;
  assign w_fcw[2] = fcw_3;
  assign w_fcw[3] = fcw_4;
  assign w_wave[0] = wave_1;
  assign w_wave[1] = wave_2;
  assign w_wave[2] = wave_3;
  assign w_wave[3] = wave_4;
  assign phase_1 = r_phase[0];
  assign phase_2 = r_phase[1];
  assign phase_3 = r_phase[2];
  assign phase_4 = r_phase[3];

  assign gen_valid    = (r_state == ST_ISSUE);
  assign sample_valid = (r_state == ST_OUTPUT);
  assign busy         = (r_state != ST_IDLE);
  assign w_to_next    = r_to_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_take    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_tick_pending) begin
          w_next = ST_ISSUE;
          w_take = 1'b1;
        end
      end
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (wave_valid) begin
          w_next = ST_MIX;
        end else if (w_to_next == TO_W'(WAIT_TIMEOUT)) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_MIX:    w_next = ST_OUTPUT;
      ST_OUTPUT: if (sample_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Enables are latched with the phases so the mix matches the voices actually requested.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (r_en[i]) w_sum = w_sum + MIX_W'(r_wave[i]);
    end
  end

`ifdef SYNTH_MIX_SAT_EN
  localparam logic signed [MIX_W-1:0] SAT_MAX = MIX_W'((1 << (WAVE_W - 1)) - 1);
  localparam logic signed [MIX_W-1:0] SAT_MIN = -SAT_MAX - 1;

  always_comb begin
    if (w_sum > SAT_MAX) begin
      w_mix = WAVE_W'(SAT_MAX);
    end else if (w_sum < SAT_MIN) begin
      w_mix = WAVE_W'(SAT_MIN);
    end else begin
      w_mix = WAVE_W'(w_sum);
    end
  end
`else
  assign w_mix = WAVE_W'(w_sum >>> 2);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_pending <= 1'b0;
      overrun_cnt    <= '0;
      timeout_err    <= 1'b0;
      r_to_cnt       <= '0;
      r_en           <= '0;
      sample_data    <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        r_phase[i] <= '0;
        r_wave[i]  <= '0;
      end
    end else begin
      // A wrap on the same edge IDLE consumes the pending tick re-arms it instead of overrunning.
      if (w_tick) begin
        if (r_tick_pending && !w_take) begin
          if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
        end else begin
          r_tick_pending <= 1'b1;
        end
      end else if (w_take) begin
        r_tick_pending <= 1'b0;
      end

      if (w_take) begin
        r_en <= voice_en;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
          r_phase[i] <= voice_en[i] ? r_phase[i] + w_fcw[i] : '0;
        end
      end

      if (r_state == ST_ISSUE) r_to_cnt <= '0;
      if (r_state == ST_WAIT)  r_to_cnt <= w_to_next;

      if ((r_state == ST_WAIT) && wave_valid) begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
          r_wave[i] <= w_wave[i];
        end
      end

      if (w_timeout) timeout_err <= 1'b1;
      if (r_state == ST_MIX) sample_data <= w_mix;
    end
  end

endmodule

// File: tb/tb_synth_voice_sequencer.sv
// Directed self-checking bench for synth_voice_sequencer with a 16-cycle sample period.
module tb_synth_voice_sequencer;
  import synth_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] fcw_1, fcw_2, fcw_3, fcw_4;
  logic [3:0]  voice_en;
  logic [23:0] phase_1, phase_2, phase_3, phase_4;
  logic        gen_valid;
  logic [20:0] wave_1, wave_2, wave_3, wave_4;
  logic        wave_valid;
  logic [20:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic [7:0]  overrun_cnt;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  synth_voice_sequencer #(
    .SAMPLE_DIV (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fcw_1        (fcw_1),
    .fcw_2        (fcw_2),
    .fcw_3        (fcw_3),
    .fcw_4        (fcw_4),
    .voice_en     (voice_en),
    .phase_1      (phase_1),
    .phase_2      (phase_2),
    .phase_3      (phase_3),
    .phase_4      (phase_4),
    .gen_valid    (gen_valid),
    .wave_1       (wave_1),
    .wave_2       (wave_2),
    .wave_3       (wave_3),
    .wave_4       (wave_4),
    .wave_valid   (wave_valid),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected mixer output for a given 23-bit sum of enabled voices.
  function automatic logic [20:0] mix_exp(input int sum);
    int r;
`ifdef SYNTH_MIX_SAT_EN
    if (sum > 1048575)       r = 1048575;
    else if (sum < -1048576) r = -1048576;
    else                     r = sum;
`else
    r = sum >>> 2;
`endif
    return r[20:0];
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_phases"}, {phase_1, phase_2, phase_3, phase_4}, '0);
    check({tag, "_gen_valid"}, gen_valid, 1'b0);
    check({tag, "_sample_valid"}, sample_valid, 1'b0);
    check({tag, "_sample_data"}, sample_data, 21'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_overrun"}, overrun_cnt, 8'd0);
    check({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  task automatic wait_issue(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gen_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_issue_seen"}, ok, 1'b1);
  endtask

  // Returns at the cycle where sample_valid first rises (or one cycle later if accepted).
  task automatic run_txn(input string tag, input logic [23:0] exp_p1, input logic [20:0] exp_data);
    bit ok;
    logic [95:0] cap;
    wait_issue(tag, ok);
    if (!ok) return;
    check({tag, "_phase1"}, phase_1, exp_p1);
    cap = {phase_1, phase_2, phase_3, phase_4};
    repeat (GEN_LATENCY) begin
      @(negedge clk);
      check({tag, "_wait_stable"}, {phase_1, phase_2, phase_3, phase_4, gen_valid, sample_valid},
            {cap, 1'b0, 1'b0});
    end
    wave_valid = 1'b1;
    @(negedge clk);
    wave_valid = 1'b0;
    check({tag, "_mix_stable"}, {phase_1, phase_2, phase_3, phase_4, busy, sample_valid},
          {cap, 1'b1, 1'b0});
    @(negedge clk);
    check({tag, "_out_valid"}, {sample_valid, phase_1, phase_2, phase_3, phase_4}, {1'b1, cap});
    check({tag, "_data"}, sample_data, exp_data);
    if (sample_ready) begin
      @(negedge clk);
      check({tag, "_done"}, {sample_valid, busy}, 2'b00);
    end
  endtask

  initial begin
    bit ok;
    logic [20:0] held;
    rst_n        = 1'b0;
    fcw_1        = 24'h004000;
    fcw_2        = 24'h111111;
    fcw_3        = 24'h222222;
    fcw_4        = 24'h333333;
    voice_en     = 4'b0001;
    wave_1       = 21'd1000;
    wave_2       = 21'd7777;
    wave_3       = 21'd7777;
    wave_4       = 21'd7777;
    wave_valid   = 1'b0;
    sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    run_txn("acc1", 24'h004000, mix_exp(1000));
    check("acc1_other_phases", {phase_2, phase_3, phase_4}, '0);
    run_txn("acc2", 24'h008000, mix_exp(1000));
    run_txn("acc3", 24'h00C000, mix_exp(1000));

    voice_en = 4'b0000;
    run_txn("disable", 24'h000000, 21'd0);

    fcw_1    = 24'hC00000;
    voice_en = 4'b0001;
    run_txn("wrap1", 24'hC00000, mix_exp(1000));
    run_txn("wrap2", 24'h800000, mix_exp(1000));
    run_txn("wrap3", 24'h400000, mix_exp(1000));

    voice_en = 4'b1111;
    wave_1 = 21'd500000; wave_2 = 21'd500000; wave_3 = 21'd500000; wave_4 = 21'd500000;
    run_txn("mix_pos", 24'h000000, mix_exp(2000000));
    wave_1 = -21'sd600000; wave_2 = -21'sd600000; wave_3 = -21'sd600000; wave_4 = -21'sd600000;
    run_txn("mix_neg", 24'hC00000, mix_exp(-2400000));

    sample_ready = 1'b0;
    wave_1 = 21'd123; wave_2 = 21'd0; wave_3 = 21'd0; wave_4 = 21'd0;
    run_txn("bp", 24'h800000, mix_exp(123));
    held = sample_data;
    for (int i = 0; i < 47; i++) begin
      @(negedge clk);
      check("bp_hold", {sample_valid, sample_data}, {1'b1, held});
    end
    check("bp_overrun", overrun_cnt, 8'd2);
    sample_ready = 1'b1;
    @(negedge clk);
    check("bp_release", sample_valid, 1'b0);
    run_txn("bp_pending", 24'h400000, mix_exp(123));
    check("bp_overrun_after", overrun_cnt, 8'd2);

    wait_issue("tmo", ok);
    check("tmo_phase1", phase_1, 24'h000000);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("tmo_no_sample", sample_valid, 1'b0);
    end
    check("tmo_pre", {timeout_err, busy}, 2'b01);
    repeat (3) @(negedge clk);
    check("tmo_post", {timeout_err, busy, sample_valid}, 3'b100);
    run_txn("tmo_next", 24'hC00000, mix_exp(123));
    check("tmo_sticky", timeout_err, 1'b1);

    wait_issue("rst", ok);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    rst_n      = 1'b1;
    wave_valid = 1'b1;
    @(negedge clk);
    wave_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_sample", {sample_valid, busy}, 2'b00);
    end
    run_txn("post_rst", 24'hC00000, mix_exp(123));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
